// File: rtl/pirad_spi_pkg.sv
// pirad_spi_pkg: shared types and constants for the PiRadSPI AXI4-Lite register slice.
// Holds the AXI response encoding, the write/read FSM state types, register byte offsets
// and the byte-lane merge helper used by the register bank.
package pirad_spi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axi_resp_t;

  typedef enum logic [2:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_COMMIT,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  // Byte offsets of the control registers as seen from the AXI side
  localparam logic [7:0] REG0_OFFSET = 8'h00;
  localparam logic [7:0] REG1_OFFSET = 8'h04;
  localparam logic [7:0] REG2_OFFSET = 8'h08;
  localparam logic [7:0] REG3_OFFSET = 8'h0C;

  // Replace only the byte lanes whose strobe bit is set
  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/pirad_spi_reg_bank.sv
// pirad_spi_reg_bank: NUM_REGS x 32-bit control registers with a byte-masked write port,
// a one-cycle write pulse per register and a combinational read mux (0 when out of range).
module pirad_spi_reg_bank
  import pirad_spi_pkg::*;
#(
  parameter int          NUM_REGS    = 4,
  parameter int          IDX_W       = 2,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [31:0]           wr_data,
  input  logic [3:0]            wr_strb,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [31:0]           rd_data,
  output logic [NUM_REGS*32-1:0] reg_q,
  output logic [NUM_REGS-1:0]   reg_wr_pulse
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic        hit;
      logic [31:0] q_reg;
      logic        pulse_reg;

      assign hit = wr_en && (wr_idx == IDX_W'(gi));

      // Register storage, updated only on the lanes enabled by the strobe
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_reg <= RESET_VALUE;
        end else if (hit) begin
          q_reg <= byte_merge(q_reg, wr_data, wr_strb);
        end
      end

      // Write notification to the SPI engine, high for the cycle after the commit
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pulse_reg <= 1'b0;
        end else begin
          pulse_reg <= hit;
        end
      end

      assign reg_q[32*gi +: 32] = q_reg;
      assign reg_wr_pulse[gi]   = pulse_reg;
    end
  endgenerate

  // Read mux; indices with no backing register read as zero
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) rd_data = reg_q[32*i +: 32];
    end
  end

endmodule

// File: rtl/pirad_spi_axil_regs.sv
// pirad_spi_axil_regs: AXI4-Lite slave front end of the PiRadSPI register file.
// Independent write and read FSMs, registered READY/VALID, register bank in a sub-module.
// Build option: define PIRADSPI_AXIL_SLVERR_EN to answer out-of-range accesses with SLVERR
// (otherwise they complete with OKAY; writes are dropped and reads return zero either way).
module pirad_spi_axil_regs
  import pirad_spi_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter int          NUM_REGS           = 4,
  parameter logic [31:0] RESET_VALUE        = 32'h0
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]          reg_q,
  output logic [NUM_REGS-1:0]             reg_wr_pulse
);

  localparam int          IDX_W      = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [31:0] NUM_REGS_U = NUM_REGS;

  wr_state_t             wr_state_reg, wr_state_next;
  rd_state_t             rd_state_reg, rd_state_next;
  logic                  awready_reg, wready_reg, bvalid_reg;
  logic                  arready_reg, rvalid_reg;
  axi_resp_t             bresp_reg, rresp_reg;
  logic [31:0]           rdata_reg;
  logic [IDX_W-1:0]      aw_idx_reg;
  logic [31:0]           wdata_reg;
  logic [3:0]            wstrb_reg;
  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                  wr_in_range, wr_commit;
  axi_resp_t             wr_resp, rd_resp;
  logic [31:0]           bank_rd_data;
  logic                  unused_bits;

  assign aw_hs = S_AXI_AWVALID && awready_reg;
  assign w_hs  = S_AXI_WVALID  && wready_reg;
  assign b_hs  = bvalid_reg    && S_AXI_BREADY;
  assign ar_hs = S_AXI_ARVALID && arready_reg;
  assign r_hs  = rvalid_reg    && S_AXI_RREADY;

  assign wr_in_range = (32'(aw_idx_reg) < NUM_REGS_U);
  assign wr_commit   = (wr_state_reg == W_COMMIT);

`ifdef PIRADSPI_AXIL_SLVERR_EN
  logic ar_in_range;
  assign ar_in_range = (32'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]) < NUM_REGS_U);
  assign wr_resp     = wr_in_range ? OKAY : SLVERR;
  assign rd_resp     = ar_in_range ? OKAY : SLVERR;
`else
  assign wr_resp = OKAY;
  assign rd_resp = OKAY;
`endif

  // Protection bits and the byte offset within a word carry no meaning here
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Write FSM next state: collect one AW and one W beat in any order, commit, then respond
  always_comb begin
    wr_state_next = wr_state_reg;
    case (wr_state_reg)
      W_IDLE: begin
        if (aw_hs && w_hs) wr_state_next = W_COMMIT;
        else if (aw_hs)    wr_state_next = W_HAVE_AW;
        else if (w_hs)     wr_state_next = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)  wr_state_next = W_COMMIT;
      W_HAVE_W:  if (aw_hs) wr_state_next = W_COMMIT;
      W_COMMIT:             wr_state_next = W_RESP;
      W_RESP:    if (b_hs)  wr_state_next = W_IDLE;
      default:              wr_state_next = W_IDLE;
    endcase
  end

  // Write FSM state and handshake flags; READYs follow the state being entered
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state_reg <= W_IDLE;
      awready_reg  <= 1'b0;
      wready_reg   <= 1'b0;
      bvalid_reg   <= 1'b0;
      bresp_reg    <= OKAY;
    end else begin
      wr_state_reg <= wr_state_next;
      awready_reg  <= (wr_state_next == W_IDLE) || (wr_state_next == W_HAVE_W);
      wready_reg   <= (wr_state_next == W_IDLE) || (wr_state_next == W_HAVE_AW);
      bvalid_reg   <= (wr_state_next == W_RESP);
      if (wr_commit) bresp_reg <= wr_resp;
    end
  end

  // Capture of the accepted address and data beats until the commit cycle
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_idx_reg <= '0;
      wdata_reg  <= '0;
      wstrb_reg  <= '0;
    end else begin
      if (aw_hs) aw_idx_reg <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      if (w_hs) begin
        wdata_reg <= S_AXI_WDATA;
        wstrb_reg <= S_AXI_WSTRB;
      end
    end
  end

  // Read FSM next state: one outstanding read, released by the R handshake
  always_comb begin
    rd_state_next = rd_state_reg;
    if (rd_state_reg == R_IDLE) begin
      if (ar_hs) rd_state_next = R_DATA;
    end else begin
      if (r_hs) rd_state_next = R_IDLE;
    end
  end

  // Read FSM state, flags and the registered read data/response
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state_reg <= R_IDLE;
      arready_reg  <= 1'b0;
      rvalid_reg   <= 1'b0;
      rdata_reg    <= '0;
      rresp_reg    <= OKAY;
    end else begin
      rd_state_reg <= rd_state_next;
      arready_reg  <= (rd_state_next == R_IDLE);
      rvalid_reg   <= (rd_state_next == R_DATA);
      if (ar_hs) begin
        rdata_reg <= bank_rd_data;
        rresp_reg <= rd_resp;
      end
    end
  end

  pirad_spi_reg_bank #(
    .NUM_REGS    (NUM_REGS),
    .IDX_W       (IDX_W),
    .RESET_VALUE (RESET_VALUE)
  ) u_reg_bank (
    .clk          (ACLK),
    .rst_n        (ARESETN),
    .wr_en        (wr_commit && wr_in_range),
    .wr_idx       (aw_idx_reg),
    .wr_data      (wdata_reg),
    .wr_strb      (wstrb_reg),
    .rd_idx       (S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]),
    .rd_data      (bank_rd_data),
    .reg_q        (reg_q),
    .reg_wr_pulse (reg_wr_pulse)
  );

  assign S_AXI_AWREADY = awready_reg;
  assign S_AXI_WREADY  = wready_reg;
  assign S_AXI_BVALID  = bvalid_reg;
  assign S_AXI_BRESP   = bresp_reg;
  assign S_AXI_ARREADY = arready_reg;
  assign S_AXI_RVALID  = rvalid_reg;
  assign S_AXI_RRESP   = rresp_reg;
  assign S_AXI_RDATA   = rdata_reg;

endmodule
